// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter sharing the single data-memory port among N requesters
// (load/store, I-fetch refill, debug/DMA). Supports bounded locked bursts and
// a watchdog that forcibly releases an owner whose transaction never completes.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req[N]     request level per requester, held until its transaction completes
//   lock[N]    keep the port after done while still requesting (bounded burst)
//   done       single-cycle pulse from memory side: current transaction complete
//   gnt[N]     registered one-hot grant
//   gnt_id     registered binary owner index (drives port mux select)
//   gnt_valid  registered, high while any grant is active
//   err        one-cycle pulse on watchdog timeout
//   err_id     index of the timed-out owner, held until the next err
//   dbg_state  current FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a requester raises req and holds it; the grant appears one cycle
// after req is first sampled high. The transaction ends on the edge where done
// is sampled high (or req drops, or the watchdog fires); a new owner may be
// granted on that same edge with no bubble.
module mem_port_arbiter #(
  parameter int N        = 4,
  parameter int IW       = 2,
  parameter int MAX_HOLD = 4,
  parameter int TIMEOUT  = 16,
  parameter int TW       = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock,
  input  logic          done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_valid,
  output logic          err,
  output logic [IW-1:0] err_id,
  output logic          dbg_state
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] wd_cnt;

  assign dbg_state = (state == BUSY);

  // Arbitration: scan cyclically from the base pointer. On a release the
  // base is the post-release pointer (owner+1) and the owner is masked out,
  // so the winner is exactly what the pointer update would produce.
  logic [N-1:0]  mask;
  logic [IW-1:0] base;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] win_id;
  logic [N-1:0]  win_oh;
  logic          win_found;
  int            idx;

  always_comb begin
    next_ptr  = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
    mask      = req;
    base      = ptr;
    if (state == BUSY) begin
      mask = req & ~gnt;
      base = next_ptr;
    end
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(base) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && mask[idx]) begin
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
    win_oh = {{(N-1){1'b0}}, 1'b1} << win_id;
  end

  // Owner-side decisions, in priority order: abandon, locked keep,
  // done release, watchdog release. done beats the watchdog.
  logic own_req;
  logic own_lock;
  logic keep;
  logic wd_hit;
  logic release_now;
  logic err_fire;

  always_comb begin
    own_req     = req[gnt_id];
    own_lock    = lock[gnt_id];
    keep        = done && own_lock && own_req && (hold_cnt < HOLD_LAST);
    wd_hit      = (wd_cnt == WD_LAST);
    release_now = !own_req || (!keep && (done || wd_hit));
    err_fire    = own_req && !done && wd_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      wd_cnt    <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      err       <= 1'b0;
      err_id    <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt       <= win_oh;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            state     <= BUSY;
            hold_cnt  <= '0;
            wd_cnt    <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            // Fairness pointer moves only on release, never during a burst.
            ptr <= next_ptr;
            if (err_fire) begin
              err    <= 1'b1;
              err_id <= gnt_id;
            end
            if (win_found) begin
              gnt       <= win_oh;
              gnt_id    <= win_id;
              gnt_valid <= 1'b1;
              hold_cnt  <= '0;
              wd_cnt    <= '0;
            end else begin
              // gnt_id intentionally keeps the last owner.
              gnt       <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end else if (keep) begin
            hold_cnt <= hold_cnt + 1'b1;
            wd_cnt   <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int N        = 4;
  localparam int IW       = 2;
  localparam int MAX_HOLD = 3;
  localparam int TIMEOUT  = 8;
  localparam int TW       = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  lock = '0;
  logic          done = 1'b0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;
  logic          err;
  logic [IW-1:0] err_id;
  logic          dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N(N), .IW(IW), .MAX_HOLD(MAX_HOLD), .TIMEOUT(TIMEOUT), .TW(TW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid),
    .err(err), .err_id(err_id), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner, pointer and counters tracked as plain integers.
  bit m_busy;
  int m_owner;
  int m_gid;
  int m_ptr;
  int m_hold;
  int m_wd;
  bit m_err;
  int m_err_id;

  function automatic int arb(input logic [N-1:0] r, input int from, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (from + k) % N;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_gid = 0; m_ptr = 0;
    m_hold = 0; m_wd = 0; m_err = 0; m_err_id = 0;
  endtask

  task automatic model_step();
    int w;
    bit rel;
    m_err = 0;
    if (!m_busy) begin
      w = arb(req, m_ptr, -1);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_gid = w; m_hold = 0; m_wd = 0;
      end
    end else begin
      rel = 0;
      if (!req[m_owner]) rel = 1;
      else if (done && lock[m_owner] && m_hold < MAX_HOLD - 1) begin
        m_hold++; m_wd = 0;
      end
      else if (done) rel = 1;
      else if (m_wd == TIMEOUT - 1) begin
        rel = 1; m_err = 1; m_err_id = m_owner;
      end
      else m_wd++;
      if (rel) begin
        m_ptr = (m_owner + 1) % N;
        w = arb(req, m_ptr, m_owner);
        if (w >= 0) begin
          m_owner = w; m_gid = w; m_hold = 0; m_wd = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ":gnt"},       32'(gnt),       m_busy ? (32'd1 << m_owner) : 32'd0);
    chk({ph, ":gnt_valid"}, 32'(gnt_valid), 32'(m_busy));
    chk({ph, ":gnt_id"},    32'(gnt_id),    32'(m_gid));
    chk({ph, ":err"},       32'(err),       32'(m_err));
    chk({ph, ":err_id"},    32'(err_id),    32'(m_err_id));
    chk({ph, ":state"},     32'(dbg_state), 32'(m_busy));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model advances on the edge, outputs checked on the falling edge.
  task automatic cycle(input string ph);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; lock = '0; done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int seq2[5];
    int seq3[5];
    seq2 = '{1, 2, 3, 0, 1};
    seq3 = '{0, 0, 0, 1, 0};

    // 1: basic grant latency and done handoff
    do_reset();
    req = 4'b1010;
    cycle("t1a");
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_id", 32'(gnt_id), 32'd1);
    done = 1'b1;
    cycle("t1b");
    chk("t1_handoff", 32'(gnt), 32'h8);
    done = 1'b0;

    // 2: all requesting, done every cycle -> rotating with no bubbles
    do_reset();
    req = 4'b1111;
    cycle("t2a");
    chk("t2_first", 32'(gnt_id), 32'd0);
    done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle("t2");
      chk("t2_seq", 32'(gnt_id), 32'(seq2[i]));
      chk("t2_valid", 32'(gnt_valid), 32'd1);
    end
    done = 1'b0;

    // 3: locked burst bounded by MAX_HOLD
    do_reset();
    lock = 4'b0001; req = 4'b0011; done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle("t3");
      chk("t3_seq", 32'(gnt_id), 32'(seq3[i]));
    end
    done = 1'b0; lock = '0;

    // 4: watchdog timeout with single requester
    do_reset();
    req = 4'b0100;
    cycle("t4a");
    for (int i = 1; i <= TIMEOUT; i++) begin
      cycle("t4");
      chk("t4_err", 32'(err), (i == TIMEOUT) ? 32'd1 : 32'd0);
    end
    chk("t4_err_id", 32'(err_id), 32'd2);
    chk("t4_gnt", 32'(gnt), 32'd0);
    cycle("t4b");

    // 5: owner abandons without done
    do_reset();
    req = 4'b0110;
    cycle("t5a");
    req = 4'b0100;
    cycle("t5b");
    chk("t5_gnt", 32'(gnt), 32'h4);
    chk("t5_err", 32'(err), 32'd0);
    // ptr is now 2: with 0 and 3 pending after 2 releases, 3 wins first
    req = 4'b1101; done = 1'b1;
    cycle("t5c");
    chk("t5_ptr", 32'(gnt_id), 32'd3);
    done = 1'b0;

    // 6: asynchronous reset while busy
    do_reset();
    req = 4'b0100;
    cycle("t6a");
    @(posedge clk);
    model_step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(gnt), 32'd0);
    chk("t6_async_valid", 32'(gnt_valid), 32'd0);
    chk("t6_async_err", 32'(err), 32'd0);
    do_reset();
    req = 4'b1000;
    cycle("t6b");
    chk("t6_gnt", 32'(gnt), 32'h8);

    // 7: randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 7) == 0) lock = N'($urandom_range(0, (1 << N) - 1));
      done = ($urandom_range(0, 5) == 0);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
